// File: rtl/unidad_control.sv
// ---------------------------------------------------------------------------
// unidad_control -- control unit for a small single-cycle CPU datapath.
//
// Purpose: BOOT/RUN/HALT sequencer plus a combinational instruction decoder.
// It also keeps a registered ALU zero flag for conditional jumps and a
// counter of retired instructions.
//
// Ports:
//   clk     in   system clock; all state changes on its rising edge
//   reset   in   asynchronous active-low reset
//   opcode  in   [5:0] instruction bits from program memory
//   z       in   live ALU zero; it only feeds the zf register
//   cont    in   resume request, only looked at in HALT
//   s_inc   out  PC source: 1 = PC+1, 0 = jump target
//   s_inm   out  register write data: 1 = immediate, 0 = ALU result
//   we3     out  register-file write enable
//   op      out  [2:0] ALU operation
//   pc_en   out  PC write enable
//   halted  out  high while in HALT
//   icount  out  [CW-1:0] retired-instruction count (wraps silently)
//   zf      out  registered zero flag
// ---------------------------------------------------------------------------
module unidad_control #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [5:0]    opcode,
    input  logic          z,
    input  logic          cont,
    output logic          s_inc,
    output logic          s_inm,
    output logic          we3,
    output logic [2:0]    op,
    output logic          pc_en,
    output logic          halted,
    output logic [CW-1:0] icount,
    output logic          zf
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          zf_q, zf_d;
    logic [CW-1:0] icount_q, icount_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= BOOT;
            zf_q     <= 1'b0;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            zf_q     <= zf_d;
            icount_q <= icount_d;
        end
    end

    always_comb begin
        // Safe values: nothing written, PC held.
        state_d  = state_q;
        zf_d     = zf_q;
        icount_d = icount_q;
        s_inc    = 1'b1;
        s_inm    = 1'b0;
        we3      = 1'b0;
        op       = 3'b000;
        pc_en    = 1'b0;

        case (state_q)
            // One idle cycle so program memory can present the first word.
            BOOT: state_d = RUN;

            RUN: begin
                pc_en    = 1'b1;
                // Every RUN cycle retires one instruction, HALT included.
                icount_d = icount_q + {{(CW-1){1'b0}}, 1'b1};
                if (!opcode[3]) begin
                    op   = opcode[2:0];
                    we3  = 1'b1;
                    zf_d = z;               // only ALU ops update the flag
                end else if (opcode[3:0] == 4'b1000) begin
                    we3   = 1'b1;
                    s_inm = 1'b1;
                end else if (opcode == 6'b001001) begin
                    s_inc = 1'b0;
                end else if (opcode == 6'b011001) begin
                    s_inc = ~zf_q;          // JZ: jump when stored zero set
                end else if (opcode == 6'b101001) begin
                    s_inc = zf_q;           // JNZ: jump when stored zero clear
                end else if (opcode == 6'b111001) begin
                    pc_en   = 1'b0;         // freeze PC on the HALT word
                    state_d = HALT;
                end
            end

            HALT: begin
                // Resuming steps the PC past the HALT instruction.
                if (cont) begin
                    pc_en   = 1'b1;
                    state_d = RUN;
                end
            end

            default: state_d = BOOT;
        endcase
    end

    assign halted = (state_q == HALT);
    assign icount = icount_q;
    assign zf     = zf_q;

endmodule

// File: tb/tb_unidad_control.sv
module tb_unidad_control;

    localparam int CW = 4;

    typedef struct packed {
        logic          s_inc;
        logic          s_inm;
        logic          we3;
        logic [2:0]    op;
        logic          pc_en;
        logic          halted;
        logic [CW-1:0] icount;
        logic          zf;
    } obs_t;

    logic          clk;
    logic          reset;
    logic [5:0]    opcode;
    logic          z;
    logic          cont;
    logic          s_inc, s_inm, we3, pc_en, halted, zf;
    logic [2:0]    op;
    logic [CW-1:0] icount;

    unidad_control #(.CW(CW)) dut (
        .clk    (clk),
        .reset  (reset),
        .opcode (opcode),
        .z      (z),
        .cont   (cont),
        .s_inc  (s_inc),
        .s_inm  (s_inm),
        .we3    (we3),
        .op     (op),
        .pc_en  (pc_en),
        .halted (halted),
        .icount (icount),
        .zf     (zf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (abstract) ----------------
    // mode: 0 = booting, 1 = running, 2 = halted
    int   m_mode;
    bit   m_zf;
    int   m_cnt;
    obs_t exp_q[$];
    string tag_q[$];
    int   n_cmp, n_bad;
    string cur_tag;

    // Instruction class: 0 ALU, 1 LI, 2 J, 3 JZ, 4 JNZ, 5 HALT, 6 NOP
    function automatic int kind(input logic [5:0] o);
        if (o[3] == 1'b0)      return 0;
        if (o[2:0] == 3'b000)  return 1;
        if (o[2:0] == 3'b001)  return 2 + int'(o[5:4]);
        return 6;
    endfunction

    task automatic cyc(input logic [5:0] opc, input logic zz,
                       input logic cc, input logic rr);
        obs_t e;
        int   nxt;
        bit   nzf;
        @(negedge clk);
        opcode = opc; z = zz; cont = cc; reset = rr;
        nxt = m_mode; nzf = m_zf;
        if (!rr) begin
            m_mode = 0; m_zf = 0; m_cnt = 0;
            nxt = 0; nzf = 0;
        end
        e.s_inc = 1'b1; e.s_inm = 1'b0; e.we3 = 1'b0; e.op = 3'b000;
        e.pc_en = 1'b0; e.halted = (m_mode == 2);
        e.icount = CW'(m_cnt); e.zf = m_zf;
        if (rr) begin
            if (m_mode == 0) begin
                nxt = 1;
            end else if (m_mode == 1) begin
                e.pc_en = 1'b1;
                case (kind(opc))
                    0: begin e.op = opc[2:0]; e.we3 = 1'b1; nzf = zz; end
                    1: begin e.we3 = 1'b1; e.s_inm = 1'b1; end
                    2: e.s_inc = 1'b0;
                    3: e.s_inc = !m_zf;
                    4: e.s_inc = m_zf;
                    5: begin e.pc_en = 1'b0; nxt = 2; end
                    default: ;
                endcase
                m_cnt = (m_cnt + 1) % (1 << CW);
            end else if (cc) begin
                e.pc_en = 1'b1;
                nxt = 1;
            end
        end
        exp_q.push_back(e);
        tag_q.push_back(cur_tag);
        m_mode = nxt; m_zf = nzf;
    endtask

    // ---------------- monitor ----------------
    initial begin
        obs_t a, e;
        string t;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = {s_inc, s_inm, we3, op, pc_en, halted, icount, zf};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL %s: got s_inc=%b s_inm=%b we3=%b op=%b pc_en=%b halted=%b icount=%0d zf=%b, want s_inc=%b s_inm=%b we3=%b op=%b pc_en=%b halted=%b icount=%0d zf=%b",
                             t, a.s_inc, a.s_inm, a.we3, a.op, a.pc_en, a.halted, a.icount, a.zf,
                             e.s_inc, e.s_inm, e.we3, e.op, e.pc_en, e.halted, e.icount, e.zf);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [5:0] ALU1 = 6'b000001;
    localparam logic [5:0] LI   = 6'b001000;
    localparam logic [5:0] JMP  = 6'b001001;
    localparam logic [5:0] JZ   = 6'b011001;
    localparam logic [5:0] JNZ  = 6'b101001;
    localparam logic [5:0] HLT  = 6'b111001;
    localparam logic [5:0] NOP  = 6'b001111;

    initial begin
        logic [5:0] pick [8];
        logic [5:0] r;
        n_cmp = 0; n_bad = 0;
        m_mode = 0; m_zf = 0; m_cnt = 0;
        opcode = '0; z = 0; cont = 0; reset = 0;
        pick[0] = ALU1; pick[1] = LI; pick[2] = JMP; pick[3] = JZ;
        pick[4] = JNZ;  pick[5] = HLT; pick[6] = NOP; pick[7] = 6'b110101;

        cur_tag = "reset";
        cyc(6'b000010, 1'b1, 1'b1, 1'b0);
        cyc(6'b000010, 1'b1, 1'b1, 1'b0);
        cur_tag = "boot";
        cyc(6'b000010, 1'b0, 1'b0, 1'b1);
        cur_tag = "first_alu";
        cyc(6'b000010, 1'b0, 1'b0, 1'b1);

        cur_tag = "jz_taken";
        cyc(ALU1, 1'b1, 1'b0, 1'b1);
        cyc(JZ,   1'b0, 1'b0, 1'b1);
        cur_tag = "jz_not_taken";
        cyc(ALU1, 1'b0, 1'b0, 1'b1);
        cyc(JZ,   1'b1, 1'b0, 1'b1);
        cur_tag = "jnz_taken";
        cyc(JNZ,  1'b1, 1'b0, 1'b1);
        cur_tag = "jump";
        cyc(JMP,  1'b1, 1'b1, 1'b1);

        cur_tag = "li_keeps_zf";
        cyc(ALU1, 1'b1, 1'b0, 1'b1);
        cyc(LI,   1'b0, 1'b0, 1'b1);
        cyc(NOP,  1'b0, 1'b0, 1'b1);

        cur_tag = "halt";
        cyc(HLT,  1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(ALU1, 1'b1, 1'b0, 1'b1);
        cur_tag = "resume";
        cyc(ALU1, 1'b1, 1'b1, 1'b1);
        cyc(NOP,  1'b0, 1'b0, 1'b1);

        cur_tag = "wrap";
        cyc(NOP, 1'b0, 1'b0, 1'b0);
        cyc(NOP, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) cyc((i % 2 == 0) ? NOP : 6'b000011, 1'b0, 1'b0, 1'b1);
        cyc(NOP, 1'b0, 1'b0, 1'b1);

        cur_tag = "async_reset";
        cyc(ALU1, 1'b1, 1'b0, 1'b1);
        cyc(ALU1, 1'b1, 1'b0, 1'b0);
        cyc(ALU1, 1'b1, 1'b1, 1'b0);
        cyc(NOP,  1'b0, 1'b0, 1'b1);

        cur_tag = "random";
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0) r = pick[$urandom_range(0, 7)];
            else r = 6'($urandom);
            cyc(r, 1'($urandom), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 59) != 0));
        end

        @(negedge clk);
        #4;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected responses left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/unidad_control.md
UNIDAD_CONTROL -- requirements
Module: unidad_control

Interface
REQ-001 The module SHALL have parameter CW, default 16, giving the width of the retired-instruction counter.
REQ-002 clk  input  1  single system clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low forces the reset state immediately, regardless of clk.
REQ-004 opcode  input  6  instruction bits [5:0] from the datapath program memory.
REQ-005 z  input  1  combinational zero output of the datapath ALU.
REQ-006 cont  input  1  resume request; sampled only in HALT.
REQ-007 s_inc  output  1  PC source select: 1 = PC+1, 0 = jump target (instruction bits [15:6]).
REQ-008 s_inm  output  1  register write-data select: 1 = immediate (bits [11:4]), 0 = ALU result.
REQ-009 we3  output  1  register-file write enable.
REQ-010 op  output  3  ALU operation code.
REQ-011 pc_en  output  1  PC write enable; 0 holds the PC.
REQ-012 halted  output  1  high while in HALT.
REQ-013 icount  output  CW  count of retired instructions.
REQ-014 zf  output  1  registered zero flag.

Function
REQ-015 The FSM SHALL have three states: BOOT, RUN and HALT.
REQ-016 Transitions SHALL be as follows:
- BOOT -> RUN unconditionally after one cycle, giving the program memory one read cycle.
- RUN -> HALT on a HALT instruction.
- HALT -> RUN when cont=1.
- HALT holds otherwise.
REQ-017 Decode SHALL apply in RUN only, with the first match winning:
- opcode[3]=0: ALU instruction; op=opcode[2:0], we3=1, s_inm=0, s_inc=1.
- opcode[3:0]=1000: load immediate; we3=1, s_inm=1, s_inc=1.
- opcode=001001: J; s_inc=0.
- opcode=011001: JZ; s_inc=~zf.
- opcode=101001: JNZ; s_inc=zf.
- opcode=111001: HALT; pc_en=0.
- Any other opcode: NOP; s_inc=1, we3=0.
REQ-018 Defaults for every output not named in REQ-017 SHALL be: we3=0, s_inm=0, op=000, s_inc=1, pc_en=1 (in RUN).
REQ-019 In BOOT, and in HALT with cont=0, outputs SHALL be we3=0, s_inm=0, op=000, s_inc=1 and pc_en=0.
REQ-020 In HALT with cont=1, outputs SHALL be pc_en=1, s_inc=1 and we3=0, so the PC steps past the HALT instruction; the state is RUN on the next cycle.
REQ-021 zf SHALL load z on a rising edge only when in RUN with an ALU instruction decoded; it SHALL hold otherwise, including during load immediate, jumps, NOP, HALT and BOOT.
REQ-022 JZ and JNZ SHALL use the registered zf, never the live z.
REQ-023 icount SHALL increment by 1 on each RUN cycle, including the HALT instruction's cycle; it SHALL not increment in BOOT or HALT.
REQ-024 icount SHALL wrap from all-ones to 0 silently.
REQ-025 Control outputs SHALL be combinational from the state, opcode and zf; z SHALL only feed zf.
REQ-026 cont SHALL be ignored outside HALT.

Reset
REQ-027 While reset=0, the module SHALL hold state=BOOT, zf=0 and icount=0, with we3=0, s_inm=0, op=000, s_inc=1, pc_en=0 and halted=0.
REQ-028 Reset asserted mid-instruction or in HALT SHALL abort immediately; no register write SHALL be enabled while reset=0.
REQ-029 After reset rises, the first RUN cycle SHALL occur on the second rising edge.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Reset release, then opcode=000010: cycle 1 BOOT with pc_en=0, we3=0; cycle 2 RUN with we3=1, op=010, s_inc=1, pc_en=1; icount=1 after the edge.
- ALU op with z=1, then JZ: zf=1, so JZ drives s_inc=0. Repeat with z=0: JZ drives s_inc=1 and JNZ drives s_inc=0.
- ALU op sets zf=1, then load immediate while z=0: zf stays 1 and we3=1, s_inm=1.
- HALT (111001): halted=1 next cycle, pc_en=0 and icount frozen for 5 cycles; cont=1 gives pc_en=1 that cycle and RUN next.
- icount preloaded at all-ones by running 2^CW instructions with CW=4: after 16 RUN cycles icount=0.
- Reset driven low mid-RUN between clock edges: outputs go to the reset values without a clock edge, and zf=0, icount=0.
